mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_pick.sv | 39 +++
 rtl/mem_arb.sv | 136 +++++++++++++
 tb/tb_mem_arb.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the CPU/VGA RAM arbiter.
// Macro MEM_ARB_VGA_PRIO_EN selects VGA-priority arbitration with CPU starvation relief.
package mem_arb_pkg;

    localparam int DEF_ADDR_W   = 12;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_MAX_WAIT = 4;

`ifdef MEM_ARB_VGA_PRIO_EN
    localparam bit VGA_PRIO_EN = 1'b1;
`else
    localparam bit VGA_PRIO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant decision for the two RAM requesters.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       a_req,
    input  logic       b_req,
    input  logic [1:0] owner,
    input  logic       promote,
    output logic       a_gnt,
    output logic       b_gnt
);

    logic a_win_s;

    // On conflict: VGA-priority mode lets A win only when promoted; otherwise alternate away from the owner.
    assign a_win_s = promote | (~VGA_PRIO_EN & (owner != OWN_A));

    // Grant select from the request pair
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        case ({a_req, b_req})
            2'b10: a_gnt = 1'b1;
            2'b01: b_gnt = 1'b1;
            2'b11: begin
                if (a_win_s) begin
                    a_gnt = 1'b1;
                end else begin
                    b_gnt = 1'b1;
                end
            end
            default: begin
                a_gnt = 1'b0;
                b_gnt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_arb.sv
// Single-port RAM arbiter between a CPU port (A, read/write) and a VGA fetch port (B, read-only).
// Optional macro MEM_ARB_VGA_PRIO_EN: B wins conflicts, A promoted after MAX_WAIT denied cycles.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_wEn,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dataIn,
    input  logic [DATA_W-1:0] ram_dataOut,
    output logic [15:0]       conflict_cnt
);

    if (MAX_WAIT < 1) begin : g_bad_max_wait
        $error("mem_arb: MAX_WAIT must be at least 1");
    end

    owner_e      owner_r;
    logic        a_req_s;
    logic        b_req_s;
    logic        promote_s;
    logic        a_rvalid_r;
    logic        b_rvalid_r;
    logic [15:0] cnt_r;

    // Requests are masked while reset is high so no grant can leak out
    assign a_req_s = a_req & ~reset;
    assign b_req_s = b_req & ~reset;

`ifdef MEM_ARB_VGA_PRIO_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    logic [WAIT_W-1:0] wait_r;

    assign promote_s = a_req_s & b_req_s & (wait_r == WAIT_W'(MAX_WAIT));

    // Count consecutive denied cycles of A
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_r <= {WAIT_W{1'b0}};
        end else if (!a_req || a_gnt) begin
            wait_r <= {WAIT_W{1'b0}};
        end else if (wait_r != WAIT_W'(MAX_WAIT)) begin
            wait_r <= wait_r + {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
            wait_r <= wait_r;
        end
    end
`else
    assign promote_s = 1'b0;
`endif

    mem_arb_pick u_pick (
        .a_req   (a_req_s),
        .b_req   (b_req_s),
        .owner   (owner_r),
        .promote (promote_s),
        .a_gnt   (a_gnt),
        .b_gnt   (b_gnt)
    );

    // Owner tracks the most recent grant
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_r <= OWN_NONE;
        end else if (a_gnt) begin
            owner_r <= OWN_A;
        end else if (b_gnt) begin
            owner_r <= OWN_B;
        end else begin
            owner_r <= owner_r;
        end
    end

    // Read-valid pipeline aligned with the RAM's one-cycle read latency
    always_ff @(posedge clock) begin
        if (reset) begin
            a_rvalid_r <= 1'b0;
            b_rvalid_r <= 1'b0;
        end else begin
            a_rvalid_r <= a_gnt & ~a_we;
            b_rvalid_r <= b_gnt;
        end
    end

    // Saturating conflict counter
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r <= 16'h0000;
        end else if (a_req && b_req && (cnt_r != 16'hFFFF)) begin
            cnt_r <= cnt_r + 16'h0001;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // A read issued just before reset must not surface while reset is high
    assign a_rvalid     = a_rvalid_r & ~reset;
    assign b_rvalid     = b_rvalid_r & ~reset;
    assign a_rdata      = a_rvalid ? ram_dataOut : {DATA_W{1'b0}};
    assign b_rdata      = b_rvalid ? ram_dataOut : {DATA_W{1'b0}};
    assign conflict_cnt = cnt_r;

    // RAM port mux driven by the granted requester
    always_comb begin
        ram_wEn    = 1'b0;
        ram_addr   = {ADDR_W{1'b0}};
        ram_dataIn = {DATA_W{1'b0}};
        if (a_gnt) begin
            ram_wEn    = a_we;
            ram_addr   = a_addr;
            ram_dataIn = a_wdata;
        end else if (b_gnt) begin
            ram_addr   = b_addr;
        end else begin
            ram_wEn    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios plus random traffic against a behavioural model.
module tb_mem_arb;

    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int MAXW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          a_req, a_we, b_req;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          ram_wEn;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dataIn, ram_dataOut;
    logic [15:0]   conflict_cnt;

    always #5 clock = ~clock;

    mem_arb dut (
        .clock        (clock),
        .reset        (reset),
        .a_req        (a_req),
        .a_we         (a_we),
        .a_addr       (a_addr),
        .a_wdata      (a_wdata),
        .a_gnt        (a_gnt),
        .a_rvalid     (a_rvalid),
        .a_rdata      (a_rdata),
        .b_req        (b_req),
        .b_addr       (b_addr),
        .b_gnt        (b_gnt),
        .b_rvalid     (b_rvalid),
        .b_rdata      (b_rdata),
        .ram_wEn      (ram_wEn),
        .ram_addr     (ram_addr),
        .ram_dataIn   (ram_dataIn),
        .ram_dataOut  (ram_dataOut),
        .conflict_cnt (conflict_cnt)
    );

    // Single-port RAM with one-cycle read latency
    logic [DW-1:0] ram [0:4095];
    always @(posedge clock) begin
        if (ram_wEn) ram[ram_addr] <= ram_dataIn;
        ram_dataOut <= ram[ram_addr];
    end

    // Reference model state
    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] shadow [0:4095];
    int            m_last = 0;   // 0 nobody yet, 1 A, 2 B
    int            m_cnt  = 0;
`ifdef MEM_ARB_VGA_PRIO_EN
    int            m_wait = 0;
`endif
    bit            m_pa = 1'b0, m_pb = 1'b0;
    logic [DW-1:0] m_pa_data = 32'h0, m_pb_data = 32'h0;
    bit            g_a = 1'b0, g_b = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit ar, input bit aw, input logic [AW-1:0] aa,
                        input logic [DW-1:0] ad, input bit br, input logic [AW-1:0] ba);
        bit ea, eb;
        @(negedge clock);
        reset = rst; a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_addr = ba;
        #1;
        ea = 1'b0;
        eb = 1'b0;
        if (!rst) begin
            if (ar && !br) ea = 1'b1;
            else if (br && !ar) eb = 1'b1;
            else if (ar && br) begin
`ifdef MEM_ARB_VGA_PRIO_EN
                if (m_wait == MAXW) ea = 1'b1; else eb = 1'b1;
`else
                if (m_last == 1) eb = 1'b1; else ea = 1'b1;
`endif
            end
        end
        chk("a_gnt", a_gnt, ea);
        chk("b_gnt", b_gnt, eb);
        chk("ram_addr", ram_addr, ea ? aa : (eb ? ba : 12'h000));
        chk("ram_wEn", ram_wEn, ea && aw);
        if (ea || rst) chk("ram_dataIn", ram_dataIn, ea ? ad : 32'h0);
        chk("a_rvalid", a_rvalid, m_pa && !rst);
        chk("a_rdata", a_rdata, (m_pa && !rst) ? m_pa_data : 32'h0);
        chk("b_rvalid", b_rvalid, m_pb && !rst);
        chk("b_rdata", b_rdata, (m_pb && !rst) ? m_pb_data : 32'h0);
        chk("conflict_cnt", conflict_cnt, m_cnt);
        g_a = ea;
        g_b = eb;
        @(posedge clock);
        m_pa = ea && !aw;
        if (ea && !aw) m_pa_data = shadow[aa];
        if (ea && aw) shadow[aa] = ad;
        m_pb = eb;
        if (eb) m_pb_data = shadow[ba];
        if (rst) begin
            m_last = 0;
            m_cnt  = 0;
`ifdef MEM_ARB_VGA_PRIO_EN
            m_wait = 0;
`endif
        end else begin
            if (ea) m_last = 1;
            else if (eb) m_last = 2;
            if (ar && br && m_cnt < 65535) m_cnt++;
`ifdef MEM_ARB_VGA_PRIO_EN
            if (!ar || ea) m_wait = 0;
            else if (m_wait < MAXW) m_wait++;
`endif
        end
    endtask

    initial begin
        bit            ra, rw, rb, rr;
        logic [AW-1:0] raddr, rbaddr;
        logic [DW-1:0] rd, v;
        for (int i = 0; i < 4096; i++) begin
            v = $urandom;
            ram[i] = v;
            shadow[i] = v;
        end
        reset = 1'b1; a_req = 1'b0; a_we = 1'b0; a_addr = 12'h0; a_wdata = 32'h0;
        b_req = 1'b0; b_addr = 12'h0;
        repeat (2) @(posedge clock);

        // Reset state, with requests present to show grants are blocked
        step(1'b1, 1'b1, 1'b1, 12'h00F, 32'h1234_5678, 1'b1, 12'h0AB);
        step(1'b1, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);

        // Lone A read, then observe rvalid
        step(1'b0, 1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 12'h000);
        step(1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);

        // A write then read-back
        step(1'b0, 1'b1, 1'b1, 12'h020, 32'hDEAD_BEEF, 1'b0, 12'h000);
        step(1'b0, 1'b1, 1'b0, 12'h020, 32'h0, 1'b0, 12'h000);
        step(1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);
        chk("readback_deadbeef", m_pa_data, 32'hDEAD_BEEF);

        // Continuous conflict from reset: alternation (or VGA priority with promotion)
        step(1'b1, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 12'h030, 32'h0, 1'b1, 12'h040);
        step(1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);

        // B read granted then reset: no rvalid must appear
        step(1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 12'h033);
        step(1'b1, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 12'h034);
        step(1'b1, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);
        step(1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);

        // Random traffic honouring hold-until-grant
        ra = 1'b0; rb = 1'b0; rw = 1'b0; raddr = 12'h0; rbaddr = 12'h0; rd = 32'h0;
        for (int i = 0; i < 400; i++) begin
            if (!ra || g_a) begin
                ra = 1'($urandom_range(0, 1));
                rw = 1'($urandom_range(0, 1));
                raddr = 12'($urandom_range(0, 15));
                rd = $urandom;
            end
            if (!rb || g_b) begin
                rb = 1'($urandom_range(0, 1));
                rbaddr = 12'($urandom_range(0, 15));
            end
            rr = ($urandom_range(0, 49) == 0);
            step(rr, ra, rw, raddr, rd, rb, rbaddr);
        end

        // Saturation of the conflict counter
        step(1'b1, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);
        for (int i = 0; i < 65540; i++) step(1'b0, 1'b1, 1'b0, 12'h005, 32'h0, 1'b1, 12'h006);
        step(1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);
        chk("conflict_sat", conflict_cnt, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
